// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//
// Pipeline register between the ID and EX stages of the five-stage pipeline.
// It resolves operand forwarding in ID, then latches the operands, immediate,
// PC+4 and control bits into EX on each rising clock edge.
//
// A load-use stall or a control-flow flush turns the latched instruction into
// a bubble. A bubble has every control bit, WriteAddr and Valid cleared. The
// registered RegWrite, WriteAddr and MemRead outputs feed back into the hazard
// unit, so a bubble can never be forwarded from or stalled on. Two saturating
// counters record how many stall bubbles and flush bubbles were inserted, for
// debug.
//
// Ports:
//   i_clk, i_rst_n          rising-edge clock, asynchronous active-low reset
//   i_LW_Stall, i_Flush     bubble requests (flush has priority over stall)
//   i_ForwardA/B            operand source: 01 EX result, 10 MEM result,
//                           otherwise register file
//   i_rs_data, i_rt_data    register file read data
//   i_EX_Result             ALU result of the instruction now in EX
//   i_MEM_Result            writeback value of the instruction now in MEM
//   i_Imm32, i_PC_Plus4     immediate and PC+4 of the ID instruction
//   i_WriteAddr, i_*        destination register and control bits
//   o_ID_EX_*               latched values presented to EX
//   o_ID_EX_Valid           1 = real instruction, 0 = bubble
//   o_Stall_Count           saturating count of stall bubbles
//   o_Flush_Count           saturating count of flush bubbles
module id_ex_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_LW_Stall,
  input  logic                  i_Flush,
  input  logic [1:0]            i_ForwardA,
  input  logic [1:0]            i_ForwardB,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  input  logic [DATA_WIDTH-1:0] i_EX_Result,
  input  logic [DATA_WIDTH-1:0] i_MEM_Result,
  input  logic [DATA_WIDTH-1:0] i_Imm32,
  input  logic [DATA_WIDTH-1:0] i_PC_Plus4,
  input  logic [4:0]            i_WriteAddr,
  input  logic                  i_RegWrite,
  input  logic                  i_MemRead,
  input  logic                  i_MemWrite,
  input  logic                  i_ALUSrc1,
  input  logic                  i_ALUSrc2,
  input  logic [1:0]            i_MemtoReg,
  input  logic [3:0]            i_ALUOp,
  output logic [DATA_WIDTH-1:0] o_ID_EX_A,
  output logic [DATA_WIDTH-1:0] o_ID_EX_B,
  output logic [DATA_WIDTH-1:0] o_ID_EX_Imm32,
  output logic [DATA_WIDTH-1:0] o_ID_EX_PC_Plus4,
  output logic [4:0]            o_ID_EX_WriteAddr,
  output logic                  o_ID_EX_RegWrite,
  output logic                  o_ID_EX_MemRead,
  output logic                  o_ID_EX_MemWrite,
  output logic                  o_ID_EX_ALUSrc1,
  output logic                  o_ID_EX_ALUSrc2,
  output logic [1:0]            o_ID_EX_MemtoReg,
  output logic [3:0]            o_ID_EX_ALUOp,
  output logic                  o_ID_EX_Valid,
  output logic [CNT_WIDTH-1:0]  o_Stall_Count,
  output logic [CNT_WIDTH-1:0]  o_Flush_Count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;
  logic                  bubble;
  logic                  stall_only;

  // Operand forwarding. Codes 00 and 11 both select the register file.
  always_comb begin
    fwd_a = i_rs_data;
    unique case (i_ForwardA)
      2'b01:   fwd_a = i_EX_Result;
      2'b10:   fwd_a = i_MEM_Result;
      default: fwd_a = i_rs_data;
    endcase
  end

  always_comb begin
    fwd_b = i_rt_data;
    unique case (i_ForwardB)
      2'b01:   fwd_b = i_EX_Result;
      2'b10:   fwd_b = i_MEM_Result;
      default: fwd_b = i_rt_data;
    endcase
  end

  // A simultaneous stall and flush inserts a single bubble, and that bubble
  // is charged to the flush counter only.
  assign bubble     = i_Flush | i_LW_Stall;
  assign stall_only = i_LW_Stall & ~i_Flush;

  // Data fields load on every edge, even for a bubble. Their value in a bubble
  // is a don't-care, but loading them keeps it deterministic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ID_EX_A        <= '0;
      o_ID_EX_B        <= '0;
      o_ID_EX_Imm32    <= '0;
      o_ID_EX_PC_Plus4 <= '0;
    end else begin
      o_ID_EX_A        <= fwd_a;
      o_ID_EX_B        <= fwd_b;
      o_ID_EX_Imm32    <= i_Imm32;
      o_ID_EX_PC_Plus4 <= i_PC_Plus4;
    end
  end

  // Control fields are zeroed for a bubble. Clearing WriteAddr keeps the
  // hazard unit from ever matching against the bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ID_EX_WriteAddr <= '0;
      o_ID_EX_RegWrite  <= 1'b0;
      o_ID_EX_MemRead   <= 1'b0;
      o_ID_EX_MemWrite  <= 1'b0;
      o_ID_EX_ALUSrc1   <= 1'b0;
      o_ID_EX_ALUSrc2   <= 1'b0;
      o_ID_EX_MemtoReg  <= '0;
      o_ID_EX_ALUOp     <= '0;
      o_ID_EX_Valid     <= 1'b0;
    end else if (bubble) begin
      o_ID_EX_WriteAddr <= '0;
      o_ID_EX_RegWrite  <= 1'b0;
      o_ID_EX_MemRead   <= 1'b0;
      o_ID_EX_MemWrite  <= 1'b0;
      o_ID_EX_ALUSrc1   <= 1'b0;
      o_ID_EX_ALUSrc2   <= 1'b0;
      o_ID_EX_MemtoReg  <= '0;
      o_ID_EX_ALUOp     <= '0;
      o_ID_EX_Valid     <= 1'b0;
    end else begin
      o_ID_EX_WriteAddr <= i_WriteAddr;
      o_ID_EX_RegWrite  <= i_RegWrite;
      o_ID_EX_MemRead   <= i_MemRead;
      o_ID_EX_MemWrite  <= i_MemWrite;
      o_ID_EX_ALUSrc1   <= i_ALUSrc1;
      o_ID_EX_ALUSrc2   <= i_ALUSrc2;
      o_ID_EX_MemtoReg  <= i_MemtoReg;
      o_ID_EX_ALUOp     <= i_ALUOp;
      o_ID_EX_Valid     <= 1'b1;
    end
  end

  // Bubble counters. Each one holds at all-ones instead of wrapping to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_Stall_Count <= '0;
      o_Flush_Count <= '0;
    end else begin
      if (stall_only && (o_Stall_Count != CNT_MAX))
        o_Stall_Count <= o_Stall_Count + 1'b1;
      if (i_Flush && (o_Flush_Count != CNT_MAX))
        o_Flush_Count <= o_Flush_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg
//
// Directed testbench for id_ex_stage_reg. The counters are built 4 bits wide
// so that saturation is reached quickly. Every expected value is written out
// by hand.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          lw_stall;
  logic          flush;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] ex_result;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] imm32;
  logic [DW-1:0] pc_plus4;
  logic [4:0]    write_addr;
  logic          reg_write;
  logic          mem_read;
  logic          mem_write;
  logic          alu_src1;
  logic          alu_src2;
  logic [1:0]    memto_reg;
  logic [3:0]    alu_op;

  logic [DW-1:0] q_a;
  logic [DW-1:0] q_b;
  logic [DW-1:0] q_imm;
  logic [DW-1:0] q_pc;
  logic [4:0]    q_waddr;
  logic          q_regwrite;
  logic          q_memread;
  logic          q_memwrite;
  logic          q_alusrc1;
  logic          q_alusrc2;
  logic [1:0]    q_memtoreg;
  logic [3:0]    q_aluop;
  logic          q_valid;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int n_cmp;
  int n_bad;

  id_ex_stage_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_LW_Stall        (lw_stall),
    .i_Flush           (flush),
    .i_ForwardA        (fwd_a_sel),
    .i_ForwardB        (fwd_b_sel),
    .i_rs_data         (rs_data),
    .i_rt_data         (rt_data),
    .i_EX_Result       (ex_result),
    .i_MEM_Result      (mem_result),
    .i_Imm32           (imm32),
    .i_PC_Plus4        (pc_plus4),
    .i_WriteAddr       (write_addr),
    .i_RegWrite        (reg_write),
    .i_MemRead         (mem_read),
    .i_MemWrite        (mem_write),
    .i_ALUSrc1         (alu_src1),
    .i_ALUSrc2         (alu_src2),
    .i_MemtoReg        (memto_reg),
    .i_ALUOp           (alu_op),
    .o_ID_EX_A         (q_a),
    .o_ID_EX_B         (q_b),
    .o_ID_EX_Imm32     (q_imm),
    .o_ID_EX_PC_Plus4  (q_pc),
    .o_ID_EX_WriteAddr (q_waddr),
    .o_ID_EX_RegWrite  (q_regwrite),
    .o_ID_EX_MemRead   (q_memread),
    .o_ID_EX_MemWrite  (q_memwrite),
    .o_ID_EX_ALUSrc1   (q_alusrc1),
    .o_ID_EX_ALUSrc2   (q_alusrc2),
    .o_ID_EX_MemtoReg  (q_memtoreg),
    .o_ID_EX_ALUOp     (q_aluop),
    .o_ID_EX_Valid     (q_valid),
    .o_Stall_Count     (stall_cnt),
    .o_Flush_Count     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle, so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every ID input to a nonzero value, with forwarding taken from the
  // register file.
  task automatic drive_nonzero();
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
    rs_data    = 32'hA5A5_0001;
    rt_data    = 32'h5A5A_0002;
    ex_result  = 32'h0000_EEEE;
    mem_result = 32'h0000_DDDD;
    imm32      = 32'h1234_5678;
    pc_plus4   = 32'h0000_0404;
    write_addr = 5'd31;
    reg_write  = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    alu_src1   = 1'b1;
    alu_src2   = 1'b1;
    memto_reg  = 2'b11;
    alu_op     = 4'hF;
  endtask

  // Drive nonzero inputs, build up counts, then assert reset between edges.
  task automatic test_reset();
    logic [DW*4+5+9+2+4+2*CW-1:0] all_out;
    rst_n = 1'b0;
    lw_stall = 1'b0;
    flush = 1'b0;
    drive_nonzero();
    #12;
    rst_n = 1'b1;
    lw_stall = 1'b1;
    tick();
    lw_stall = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_cmp++;
    if (q_valid !== 1'b1 || stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
      n_bad++;
      $display("[TB] FAIL pre_reset: valid=%0b stall=%0d flush=%0d, need 1/1/1",
               q_valid, stall_cnt, flush_cnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    all_out = {q_a, q_b, q_imm, q_pc, q_waddr, q_regwrite, q_memread,
               q_memwrite, q_alusrc1, q_alusrc2, q_memtoreg, q_aluop, q_valid,
               stall_cnt, flush_cnt};
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_all: outputs=%h, need all zero", all_out);
    end
    n_cmp++;
    if (q_a !== 32'd0 || q_imm !== 32'd0 || q_pc !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_data: A=%h Imm=%h PC=%h, need 0", q_a, q_imm, q_pc);
    end
    tick();
    n_cmp++;
    if (q_valid !== 1'b0 || q_a !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_hold: valid=%0b A=%h, need 0 while in reset",
               q_valid, q_a);
    end
    #2;
    rst_n = 1'b1;
  endtask

  // Step each forwarding select through all four codes.
  task automatic test_forwarding();
    logic [1:0]    codes [4];
    logic [DW-1:0] want  [4];
    codes = '{2'b00, 2'b01, 2'b10, 2'b11};
    want  = '{32'h11, 32'h22, 32'h33, 32'h11};
    drive_nonzero();
    rs_data    = 32'h11;
    rt_data    = 32'h11;
    ex_result  = 32'h22;
    mem_result = 32'h33;
    for (int i = 0; i < 4; i++) begin
      fwd_a_sel = codes[i];
      fwd_b_sel = 2'b00;
      tick();
      n_cmp++;
      if (q_a !== want[i] || q_b !== 32'h11) begin
        n_bad++;
        $display("[TB] FAIL fwd_a[%0d]: A=%h B=%h, need A=%h B=11", i, q_a, q_b, want[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = codes[i];
      tick();
      n_cmp++;
      if (q_b !== want[i] || q_a !== 32'h11) begin
        n_bad++;
        $display("[TB] FAIL fwd_b[%0d]: B=%h A=%h, need B=%h A=11", i, q_b, q_a, want[i]);
      end
    end
    fwd_b_sel = 2'b00;
  endtask

  // One load-use bubble followed by the same instruction entering normally.
  task automatic test_load_use();
    drive_nonzero();
    rs_data    = 32'h0000_0777;
    reg_write  = 1'b1;
    write_addr = 5'd5;
    mem_read   = 1'b1;
    lw_stall   = 1'b1;
    tick();
    n_cmp++;
    if (q_regwrite !== 1'b0 || q_waddr !== 5'd0 || q_memread !== 1'b0 ||
        q_valid !== 1'b0 || q_memwrite !== 1'b0 || q_aluop !== 4'd0 ||
        q_memtoreg !== 2'd0 || q_alusrc1 !== 1'b0 || q_alusrc2 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL stall_bubble: rw=%0b wa=%0d mr=%0b mw=%0b op=%h m2r=%0d s1=%0b s2=%0b v=%0b, need all 0",
               q_regwrite, q_waddr, q_memread, q_memwrite, q_aluop, q_memtoreg,
               q_alusrc1, q_alusrc2, q_valid);
    end
    n_cmp++;
    if (stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL stall_count: stall=%0d flush=%0d, need 1/0", stall_cnt, flush_cnt);
    end
    n_cmp++;
    if (q_a !== 32'h0000_0777 || q_imm !== 32'h1234_5678) begin
      n_bad++;
      $display("[TB] FAIL stall_data: A=%h Imm=%h, need 777/12345678", q_a, q_imm);
    end
    lw_stall = 1'b0;
    tick();
    n_cmp++;
    if (q_regwrite !== 1'b1 || q_waddr !== 5'd5 || q_valid !== 1'b1 ||
        q_memread !== 1'b1 || q_aluop !== 4'hF) begin
      n_bad++;
      $display("[TB] FAIL stall_release: rw=%0b wa=%0d v=%0b mr=%0b op=%h, need 1/5/1/1/f",
               q_regwrite, q_waddr, q_valid, q_memread, q_aluop);
    end
    n_cmp++;
    if (stall_cnt !== 4'd1) begin
      n_bad++;
      $display("[TB] FAIL stall_count_hold: stall=%0d, need 1", stall_cnt);
    end
  endtask

  // Flush together with a stall: one bubble, charged to the flush counter.
  task automatic test_flush_priority();
    lw_stall = 1'b1;
    flush    = 1'b1;
    tick();
    n_cmp++;
    if (q_valid !== 1'b0 || q_regwrite !== 1'b0 || q_waddr !== 5'd0) begin
      n_bad++;
      $display("[TB] FAIL flush_bubble: v=%0b rw=%0b wa=%0d, need 0/0/0",
               q_valid, q_regwrite, q_waddr);
    end
    n_cmp++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
      n_bad++;
      $display("[TB] FAIL flush_counts: flush=%0d stall=%0d, need 1/1", flush_cnt, stall_cnt);
    end
    lw_stall = 1'b0;
    tick();
    n_cmp++;
    if (flush_cnt !== 4'd2 || stall_cnt !== 4'd1 || q_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL flush_alone: flush=%0d stall=%0d v=%0b, need 2/1/0",
               flush_cnt, stall_cnt, q_valid);
    end
    flush = 1'b0;
    tick();
    n_cmp++;
    if (q_valid !== 1'b1 || flush_cnt !== 4'd2) begin
      n_bad++;
      $display("[TB] FAIL flush_release: v=%0b flush=%0d, need 1/2", q_valid, flush_cnt);
    end
  endtask

  // Hold a stall for 20 cycles. The 4-bit stall counter starts at 1 here.
  task automatic test_saturation();
    logic [CW-1:0] want;
    int bad_steps;
    want = 4'd1;
    bad_steps = 0;
    lw_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      want = (want == 4'd15) ? 4'd15 : want + 4'd1;
      if (stall_cnt !== want) begin
        bad_steps++;
        $display("[TB] FAIL sat_step[%0d]: stall=%0d, need %0d", i, stall_cnt, want);
      end
    end
    n_cmp++;
    if (bad_steps != 0) n_bad++;
    n_cmp++;
    if (stall_cnt !== 4'd15 || flush_cnt !== 4'd2) begin
      n_bad++;
      $display("[TB] FAIL sat_final: stall=%0d flush=%0d, need 15/2", stall_cnt, flush_cnt);
    end
    lw_stall = 1'b0;
  endtask

  // Reset asserted partway through a 3-cycle stall, released with no stall.
  task automatic test_reset_mid_stall();
    drive_nonzero();
    write_addr = 5'd9;
    lw_stall = 1'b1;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || q_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midstall_reset: stall=%0d flush=%0d v=%0b, need 0/0/0",
               stall_cnt, flush_cnt, q_valid);
    end
    lw_stall = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (q_valid !== 1'b1 || q_waddr !== 5'd9 || q_regwrite !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL midstall_release: v=%0b wa=%0d rw=%0b, need 1/9/1",
               q_valid, q_waddr, q_regwrite);
    end
    n_cmp++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL midstall_counts: stall=%0d flush=%0d, need 0/0",
               stall_cnt, flush_cnt);
    end
  endtask

  // Run all scenarios in order, then report.
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_priority();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between ID and EX in the five-stage pipeline processor. It selects forwarded operands in ID according to the hazard unit's ForwardA/ForwardB codes, then latches the operands, immediate, PC+4 and control bits into EX. On a load-use stall or a control-flow flush it inserts a bubble. Its registered RegWrite, WriteAddr and MemRead outputs feed back into the hazard unit for the next instruction's comparison. It also keeps saturating counters of stall bubbles and flush bubbles for debug.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/immediate/PC width
- CNT_WIDTH, 16, width of each bubble counter

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_LW_Stall  in  1  load-use stall request from hazard unit
- i_Flush  in  1  branch/jump flush of the instruction in ID
- i_ForwardA  in  2  rs source: 00 regfile, 01 EX result, 10 MEM result, 11 regfile
- i_ForwardB  in  2  rt source, same encoding
- i_rs_data, i_rt_data  in  DATA_WIDTH  register file read data
- i_EX_Result  in  DATA_WIDTH  ALU result of the instruction currently in EX
- i_MEM_Result  in  DATA_WIDTH  writeback value of the instruction currently in MEM
- i_Imm32  in  DATA_WIDTH  extended immediate
- i_PC_Plus4  in  DATA_WIDTH  PC+4 of the ID instruction
- i_WriteAddr  in  5  destination register
- i_RegWrite, i_MemRead, i_MemWrite, i_ALUSrc1, i_ALUSrc2  in  1 each  control bits
- i_MemtoReg  in  2  writeback select
- i_ALUOp  in  4  ALU operation
- o_ID_EX_A, o_ID_EX_B  out  DATA_WIDTH  latched (forwarded) operands
- o_ID_EX_Imm32, o_ID_EX_PC_Plus4  out  DATA_WIDTH  latched
- o_ID_EX_WriteAddr  out  5  latched destination
- o_ID_EX_RegWrite, o_ID_EX_MemRead, o_ID_EX_MemWrite, o_ID_EX_ALUSrc1, o_ID_EX_ALUSrc2  out  1 each
- o_ID_EX_MemtoReg  out  2
- o_ID_EX_ALUOp  out  4
- o_ID_EX_Valid  out  1  1 = real instruction, 0 = bubble
- o_Stall_Count, o_Flush_Count  out  CNT_WIDTH  saturating bubble counters

## Operation
- **Forwarding mux (combinational).**
  - fwdA = i_EX_Result when i_ForwardA=01, i_MEM_Result when 10, otherwise i_rs_data.
  - fwdB is selected the same way from i_ForwardB and i_rt_data.
- **Priority per cycle:** flush > stall > load. Each mode applies at the rising edge.
- **Load (no flush, no stall):**
  - All o_ID_EX_* outputs take their corresponding inputs.
  - A and B take fwdA and fwdB.
  - Valid is set to 1.
- **Bubble (stall or flush):**
  - RegWrite, MemRead, MemWrite, ALUSrc1, ALUSrc2, MemtoReg, ALUOp, WriteAddr and Valid are cleared to 0.
  - A, B, Imm32 and PC_Plus4 still load their normal values (don't-care, but deterministic).
  - WriteAddr=0 guarantees the hazard unit never forwards from or stalls on a bubble.
- **Counters:**
  - o_Stall_Count increments on each cycle with i_LW_Stall=1 and i_Flush=0.
  - o_Flush_Count increments on each cycle with i_Flush=1, whether or not i_LW_Stall is asserted.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
- **Scope:** this block does not hold PC or IF/ID. Freezing those during a stall is the fetch stage's job.

## Timing
- **Reset:** i_rst_n=0 clears every output to 0 immediately, with no clock required. This includes Valid, both counters, A, B, Imm32 and PC_Plus4.
- **Reset release:** the first rising edge with i_rst_n=1 performs a normal update.
- **Latency:** one cycle from ID inputs to o_ID_EX_* outputs.
- **Forwarding inputs:** i_EX_Result and i_MEM_Result are sampled at the same edge as the ID fields, so no extra latency is added.
- **Consecutive stalls:** a stall held for N cycles produces N consecutive bubbles and adds N to o_Stall_Count.
- **Simultaneous stall and flush:** one bubble is inserted and only o_Flush_Count increments.
- **Reset mid-stall:** outputs clear immediately, and the stall does not persist after release.

## Test plan
1. **Reset values.**
   - Stimulus: drive every input to nonzero values, then assert i_rst_n=0 between clock edges.
   - Required response: all outputs read 0 before the next edge.
2. **Forwarding select.**
   - Stimulus: i_rs_data=0x11, i_EX_Result=0x22, i_MEM_Result=0x33, with i_ForwardA stepped through 00, 01, 10, 11 on successive edges.
   - Required response: o_ID_EX_A reads 0x11, 0x22, 0x33, 0x11.
   - Repeat with i_ForwardB: o_ID_EX_B must follow the same pattern.
3. **Load-use bubble.**
   - Stimulus: i_RegWrite=1, i_WriteAddr=5, i_MemRead=1, i_LW_Stall=1 for one cycle.
   - Required response: RegWrite=0, WriteAddr=0, MemRead=0, Valid=0 and o_Stall_Count=1.
   - Next cycle, with the stall released: RegWrite=1, WriteAddr=5, Valid=1.
4. **Flush priority.**
   - Stimulus: i_Flush=1 and i_LW_Stall=1 together for one cycle.
   - Required response: a bubble is inserted, o_Flush_Count=1 and o_Stall_Count is unchanged.
5. **Counter saturation.**
   - Stimulus: CNT_WIDTH=4, hold i_LW_Stall=1 for 20 cycles.
   - Required response: o_Stall_Count stops at 15 and never wraps to 0.
6. **Reset during a stall burst.**
   - Stimulus: during a 3-cycle stall, assert i_rst_n=0 mid-cycle, then release it with the stall deasserted.
   - Required response: counters read 0 and the first post-release edge loads a Valid=1 instruction.
